// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and constants for the async-FIFO write-side arbiter.
package fifo_wr_arb_pkg;

  localparam int unsigned BEAT_W = 5;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Saturating increment used by the optional statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester strictly after rr_ptr, wrapping.
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [NREQ-1:0]         pick_oh,
  output logic [$clog2(NREQ)-1:0] pick_idx,
  output logic                    pick_vld
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % NREQ);
      if (!pick_vld && req[cand]) begin
        pick_vld      = 1'b1;
        pick_idx      = cand;
        pick_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding the write side of an async FIFO.
// Optional per-requester word / stall counters under FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BURST = 4
) (
  input  logic                      wclk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           gnt,
  input  logic                      fifo_full,
  output logic                      fifo_wen,
  output logic [WIDTH-1:0]          fifo_wdata,
  output logic [$clog2(NREQ)-1:0]   owner
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0]    stat_words,
  output logic [STAT_W-1:0]         stat_stall
`endif
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   gnt_d;
  logic [IDX_W-1:0]  owner_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              xfer;
  logic              end_gnt;

  logic [NREQ-1:0]   pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req      (req),
    .rr_ptr   (rr_ptr_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  // State and grant registers.
  always_ff @(posedge wclk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      beat_q   <= '0;
      rr_ptr_q <= IDX_W'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      owner    <= owner_d;
      beat_q   <= beat_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state: arbitrate in IDLE, stream words in GRANT, freeze while the FIFO is full.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt;
    owner_d  = owner;
    beat_d   = beat_q;
    rr_ptr_d = rr_ptr_q;
    xfer     = 1'b0;
    end_gnt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          gnt_d   = pick_oh;
          owner_d = pick_idx;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (!fifo_full) begin
          if (req[owner]) begin
            xfer    = 1'b1;
            beat_d  = beat_q + BEAT_W'(1);
            end_gnt = req_last[owner] || (beat_d == BEAT_W'(BURST));
          end else begin
            end_gnt = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (end_gnt) begin
      state_d  = IDLE;
      gnt_d    = '0;
      rr_ptr_d = owner;
    end
  end

  // Write strobe is same-cycle; suppressed while reset is asserted so an aborted burst emits nothing.
  assign fifo_wen   = xfer & ~rst;
  assign fifo_wdata = req_data[32'(owner)*WIDTH +: WIDTH];

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STAT_W-1:0] words_q [NREQ];

  // Saturating accepted-word and full-stall counters.
  always_ff @(posedge wclk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) words_q[i] <= '0;
      stat_stall <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (xfer && (owner == IDX_W'(i))) words_q[i] <= sat_inc(words_q[i]);
      end
      if ((state_q == GRANT) && fifo_full) stat_stall <= sat_inc(stat_stall);
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_words[g*STAT_W +: STAT_W] = words_q[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a grant-session model.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 4;
  localparam int DEPTH = 256;

  logic        wclk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        fifo_wen;
  logic [7:0]  fifo_wdata;
  logic [1:0]  owner;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [63:0] stat_words;
  logic [15:0] stat_stall;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .wclk       (wclk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .gnt        (gnt),
    .fifo_full  (fifo_full),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .owner      (owner)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_stall (stat_stall)
`endif
  );

  always #5 wclk = ~wclk;

  // Requester sources: each holds a list of {last,data} words, req high while non-empty.
  logic [8:0] mem [NREQ][DEPTH];
  int         hd [NREQ];
  int         tl [NREQ];

  // Reference model: one grant session at a time.
  bit m_busy;
  int m_owner;
  int m_beats;
  int m_prev;
  int m_words [NREQ];
  int m_stall;

  logic [7:0] wlog [$];
  int         glog [$];
  logic [3:0] prev_gnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NREQ; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
  endtask

  task automatic push_word(input int r, input logic [7:0] d, input logic l);
    mem[r][tl[r] % DEPTH] = {l, d};
    tl[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (hd[i] != tl[i]);
      {req_last[i], req_data[i*8 +: 8]} = (hd[i] != tl[i]) ? mem[i][hd[i] % DEPTH] : 9'h000;
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_beats = 0;
    m_prev  = NREQ - 1;
    m_stall = 0;
    for (int i = 0; i < NREQ; i++) m_words[i] = 0;
  endtask

  // One clock: check outputs at negedge, then advance the model past the posedge.
  task automatic cycle();
    bit   xfer;
    bit   lastw;
    int   nxt;
    drive();
    @(negedge wclk);
    xfer = !rst && m_busy && req[m_owner] && !fifo_full;
    chk("gnt", 32'(gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
    if (m_busy) chk("owner", 32'(owner), 32'(m_owner));
    chk("fifo_wen", 32'(fifo_wen), 32'(xfer));
    if (xfer) chk("fifo_wdata", 32'(fifo_wdata), 32'(mem[m_owner][hd[m_owner] % DEPTH][7:0]));
    if (fifo_wen === 1'b1) wlog.push_back(fifo_wdata);
    if ((gnt != 4'b0) && (prev_gnt == 4'b0)) glog.push_back(int'(owner));
    prev_gnt = gnt;
    @(posedge wclk);
    #1;
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = 1; k <= NREQ; k++) begin
        nxt = (m_prev + k) % NREQ;
        if (!m_busy && req[nxt]) begin
          m_busy  = 1'b1;
          m_owner = nxt;
          m_beats = 0;
        end
      end
    end else if (fifo_full) begin
      m_stall++;
    end else if (xfer) begin
      lastw = mem[m_owner][hd[m_owner] % DEPTH][8];
      hd[m_owner]++;
      m_words[m_owner]++;
      m_beats++;
      if (lastw || (m_beats == BURST)) begin
        m_busy = 1'b0;
        m_prev = m_owner;
      end
    end else begin
      m_busy = 1'b0;
      m_prev = m_owner;
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    wlog.delete();
    glog.delete();
  endtask

  task automatic chk_wlog(input string tag, input int n, input logic [7:0] exp [8]);
    chk({tag, "_nwords"}, 32'(wlog.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < wlog.size()) chk(tag, 32'(wlog[i]), 32'(exp[i]));
    end
  endtask

  logic [7:0] exp_w [8];

  initial begin
    rst       = 1'b1;
    fifo_full = 1'b0;
    prev_gnt  = 4'b0;
    clear_sources();
    model_reset();
    drive();
    @(posedge wclk);
    #1;

    // Reset state.
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_wen", 32'(fifo_wen), 32'h0);

    // Single requester burst A0..A3 terminated by last.
    for (int i = 0; i < 4; i++) push_word(0, 8'(8'hA0 + i), i == 3);
    repeat (8) cycle();
    exp_w = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00};
    chk_wlog("single_burst", 4, exp_w);
    chk("single_ngrants", 32'(glog.size()), 32'd1);

    // All four requesting, no last: round-robin 4-word bursts, 20 grants total.
    clear_sources();
    do_reset();
    for (int r = 0; r < NREQ; r++)
      for (int k = 0; k < 20; k++) push_word(r, 8'(r * 64 + k), 1'b0);
    repeat (110) cycle();
    chk("rr_ngrants", 32'(glog.size()), 32'd20);
    chk("rr_nwords", 32'(wlog.size()), 32'd80);
    for (int i = 0; i < 5; i++) begin
      if (i < glog.size()) chk("rr_order", 32'(glog[i]), 32'(i % 4));
    end
`ifdef FIFO_WR_ARB_STATS_EN
    for (int r = 0; r < NREQ; r++) chk("stat_words", 32'(stat_words[r*16 +: 16]), 32'd20);
    chk("stat_stall", 32'(stat_stall), 32'd0);
`endif

    // FIFO full for three cycles after requester 2's second word.
    clear_sources();
    do_reset();
    for (int i = 0; i < 4; i++) push_word(2, 8'(8'hC0 + i), 1'b0);
    repeat (3) cycle();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("full_gnt_held", 32'(gnt), 32'h4);
      chk("full_no_wen", 32'(fifo_wen), 32'h0);
    end
    fifo_full = 1'b0;
    repeat (5) cycle();
    exp_w = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00};
    chk_wlog("full_stall", 4, exp_w);

    // Requester 1 drops req after one word; requester 2 follows.
    clear_sources();
    do_reset();
    push_word(1, 8'hB0, 1'b0);
    push_word(2, 8'hB1, 1'b0);
    push_word(2, 8'hB2, 1'b1);
    repeat (10) cycle();
    chk("drop_ngrants", 32'(glog.size()), 32'd2);
    if (glog.size() >= 2) begin
      chk("drop_first", 32'(glog[0]), 32'd1);
      chk("drop_next", 32'(glog[1]), 32'd2);
    end
    exp_w = '{8'hB0, 8'hB1, 8'hB2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    chk_wlog("drop", 3, exp_w);

    // Reset during requester 3's second word, then all request: 0 wins.
    clear_sources();
    do_reset();
    for (int i = 0; i < 4; i++) push_word(3, 8'(8'hD0 + i), 1'b0);
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("abort_gnt", 32'(gnt), 32'h0);
    chk("abort_wen", 32'(fifo_wen), 32'h0);
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) push_word(r, 8'(8'hE0 + r * 4 + i), i == 3);
    cycle();
    chk("after_abort_gnt", 32'(gnt), 32'h1);
    repeat (30) cycle();
    chk("abort_first_word", 32'(wlog.size() > 0 ? wlog[0] : 8'h00), 32'hD0);

    // Random traffic, random full and occasional reset.
    clear_sources();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (($urandom_range(0, 3) == 0) && ((tl[r] - hd[r]) < 200))
          push_word(r, 8'($urandom), $urandom_range(0, 4) == 0);
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst       = 1'b0;
    fifo_full = 1'b0;
    repeat (20) cycle();
`ifdef FIFO_WR_ARB_STATS_EN
    for (int r = 0; r < NREQ; r++) chk("rand_stat_words", 32'(stat_words[r*16 +: 16]), 32'(m_words[r]));
    chk("rand_stat_stall", 32'(stat_stall), 32'(m_stall));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
